// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Pays out a latched return amount as physical coins, one per
//                cycle, greedy largest-denomination first. Signals completion
//                with a one-cycle done pulse plus the undispensable residue.
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int NUM_COINS  = 3,
    parameter int TOTAL_BITS = 31,
    parameter int COIN_VAL0  = 100,
    parameter int COIN_VAL1  = 500,
    parameter int COIN_VAL2  = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_trigger_return,
    input  logic [TOTAL_BITS-1:0] i_return_total,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_remainder,
    output logic [7:0]            o_coin_count
);

    localparam logic [TOTAL_BITS-1:0] C_VAL0 = TOTAL_BITS'(COIN_VAL0);
    localparam logic [TOTAL_BITS-1:0] C_VAL1 = TOTAL_BITS'(COIN_VAL1);
    localparam logic [TOTAL_BITS-1:0] C_VAL2 = TOTAL_BITS'(COIN_VAL2);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_DISPENSE = 2'b01,
        S_DONE     = 2'b10
    } state_t;

    state_t                r_state;
    logic [TOTAL_BITS-1:0] r_remaining;
    logic [TOTAL_BITS-1:0] r_remainder;
    logic [7:0]            r_coin_count;
    logic                  r_busy;
    logic                  r_done;

    logic [NUM_COINS-1:0]  w_coin_sel;
    logic [TOTAL_BITS-1:0] w_coin_val;
    logic [TOTAL_BITS-1:0] w_rem_next;
    logic                  w_coin_hit;

    // Greedy coin choice from registered state only, so the coin output is Moore
    always_comb begin
        w_coin_sel = '0;
        w_coin_val = '0;
        if (r_state == S_DISPENSE) begin
            if (r_remaining >= C_VAL2) begin
                w_coin_sel = NUM_COINS'(1) << 2;
                w_coin_val = C_VAL2;
            end else if (r_remaining >= C_VAL1) begin
                w_coin_sel = NUM_COINS'(1) << 1;
                w_coin_val = C_VAL1;
            end else if (r_remaining >= C_VAL0) begin
                w_coin_sel = NUM_COINS'(1);
                w_coin_val = C_VAL0;
            end
        end
    end

    // A coin is only chosen when it fits, so this subtraction cannot underflow
    assign w_rem_next = r_remaining - w_coin_val;
    assign w_coin_hit = |w_coin_sel;

    // Transaction state machine: latch amount, dispense coins, pulse done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_remainder  <= '0;
            r_coin_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_trigger_return) begin
                        r_remaining  <= i_return_total;
                        r_remainder  <= '0;
                        r_coin_count <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (w_coin_hit) begin
                        r_remaining <= w_rem_next;
                        if (r_coin_count != 8'hFF) begin
                            r_coin_count <= r_coin_count + 8'd1;
                        end
                        if (w_rem_next < C_VAL0) begin
                            r_remainder <= w_rem_next;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else begin
                        r_remainder <= r_remaining;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_return_coin = w_coin_sel;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_remainder   = r_remainder;
    assign o_coin_count  = r_coin_count;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_dispenser
//  Description : Scoreboard bench for change_dispenser. Stimulus pushes the
//                expected coins/done records; a monitor compares them as the
//                DUT presents coins and done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    logic        clk;
    logic        reset_n;
    logic        i_trigger_return;
    logic [30:0] i_return_total;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_remainder;
    logic [7:0]  o_coin_count;

    change_dispenser dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_trigger_return(i_trigger_return),
        .i_return_total  (i_return_total),
        .o_return_coin   (o_return_coin),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_remainder     (o_remainder),
        .o_coin_count    (o_coin_count)
    );

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } coin_t;

    typedef struct {
        logic [30:0] rem;
        logic [7:0]  cnt;
        int          cyc;
    } done_t;

    coin_t coin_q[$];
    done_t done_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the index of the most recent rising edge
    always @(posedge clk) cyc++;

    // Monitor: compare every presented coin and done pulse against the scoreboard
    always @(negedge clk) begin
        coin_t ec;
        done_t ed;
        if (reset_n) begin
            if (o_return_coin != 3'b000) begin
                checks++;
                if (coin_q.size() == 0) begin
                    failures++;
                    $display("FAIL coin_extra: got coin=%b at cycle %0d, required none", o_return_coin, cyc);
                end else begin
                    ec = coin_q.pop_front();
                    if (o_return_coin !== ec.code || cyc != ec.cyc || o_busy !== 1'b1) begin
                        failures++;
                        $display("FAIL coin: got coin=%b cyc=%0d busy=%b, required coin=%b cyc=%0d busy=1",
                                 o_return_coin, cyc, o_busy, ec.code, ec.cyc);
                    end
                end
            end
            if (o_done) begin
                checks++;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_extra: got done at cycle %0d, required none", cyc);
                end else begin
                    ed = done_q.pop_front();
                    if (o_remainder !== ed.rem || o_coin_count !== ed.cnt || cyc != ed.cyc || o_busy !== 1'b1) begin
                        failures++;
                        $display("FAIL done: got rem=%0d cnt=%0d cyc=%0d busy=%b, required rem=%0d cnt=%0d cyc=%0d busy=1",
                                 o_remainder, o_coin_count, cyc, o_busy, ed.rem, ed.cnt, ed.cyc);
                    end
                end
            end
        end
    end

    task automatic push_coin(input logic [2:0] code, input int c);
        coin_t e;
        e.code = code;
        e.cyc  = c;
        coin_q.push_back(e);
    endtask

    task automatic push_done(input logic [30:0] rem, input logic [7:0] cnt, input int c);
        done_t e;
        e.rem = rem;
        e.cnt = cnt;
        e.cyc = c;
        done_q.push_back(e);
    endtask

    // Raise the trigger; b is the cycle in which the first coin is expected
    task automatic trig(input logic [30:0] total, output int b);
        @(negedge clk);
        i_trigger_return = 1'b1;
        i_return_total   = total;
        b = cyc + 1;
    endtask

    task automatic release_trig();
        @(negedge clk);
        i_trigger_return = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done within %0d cycles, required done", name, budget);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (o_return_coin !== 3'b000 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL %s: got coin=%b busy=%b done=%b, required 000/0/0",
                     name, o_return_coin, o_busy, o_done);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        i_trigger_return = 1'b0;
        i_return_total   = '0;

        // Reset state
        #1;
        checks++;
        if (o_return_coin !== 3'b000 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_remainder !== 31'd0 || o_coin_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got coin=%b busy=%b done=%b rem=%0d cnt=%0d, required all 0",
                     o_return_coin, o_busy, o_done, o_remainder, o_coin_count);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-payout of 1700: one coin out, then an immediate asynchronous abort
        trig(31'd1700, base);
        push_coin(3'b100, base);
        release_trig();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (o_return_coin !== 3'b000 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_remainder !== 31'd0 || o_coin_count !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: got coin=%b busy=%b done=%b rem=%0d cnt=%0d, required all 0",
                     o_return_coin, o_busy, o_done, o_remainder, o_coin_count);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("post_reset_idle");

        // 1700 -> 1000, 500, 100, 100
        trig(31'd1700, base);
        push_coin(3'b100, base);
        push_coin(3'b010, base + 1);
        push_coin(3'b001, base + 2);
        push_coin(3'b001, base + 3);
        push_done(31'd0, 8'd4, base + 4);
        release_trig();
        wait_done("t1700", 20);

        // 50 -> no coins, done two cycles after the trigger edge
        trig(31'd50, base);
        push_done(31'd50, 8'd0, base + 1);
        release_trig();
        wait_done("t50", 20);

        // 2650 with a re-trigger of 500 while busy (must be ignored)
        trig(31'd2650, base);
        push_coin(3'b100, base);
        push_coin(3'b100, base + 1);
        push_coin(3'b010, base + 2);
        push_coin(3'b001, base + 3);
        push_done(31'd50, 8'd4, base + 4);
        release_trig();
        i_trigger_return = 1'b1;
        i_return_total   = 31'd500;
        @(negedge clk);
        i_trigger_return = 1'b0;
        wait_done("t2650", 20);

        // 600 raised in the idle cycle right after done
        trig(31'd600, base);
        push_coin(3'b010, base);
        push_coin(3'b001, base + 1);
        push_done(31'd0, 8'd2, base + 2);
        release_trig();
        wait_done("t600", 20);

        // 1799 -> 1000, 500, 100, 100, residue 99
        trig(31'd1799, base);
        push_coin(3'b100, base);
        push_coin(3'b010, base + 1);
        push_coin(3'b001, base + 2);
        push_coin(3'b001, base + 3);
        push_done(31'd99, 8'd4, base + 4);
        release_trig();
        wait_done("t1799", 20);

        // 0 -> no coins, remainder 0
        trig(31'd0, base);
        push_done(31'd0, 8'd0, base + 1);
        release_trig();
        wait_done("t0", 20);

        // 300000 -> 300 coins of 1000, count saturates at 255
        trig(31'd300000, base);
        for (int i = 0; i < 300; i++) push_coin(3'b100, base + i);
        push_done(31'd0, 8'd255, base + 300);
        release_trig();
        wait_done("t300000", 400);

        repeat (3) @(negedge clk);
        check_idle("final_idle");

        checks++;
        if (coin_q.size() != 0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d coins and %0d dones still expected, required 0/0",
                     coin_q.size(), done_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
